// File: rtl/sl_transmitter.sv
// rtl/sl_transmitter.sv - SL word transmitter: data bits, odd parity and stop bit on the two-wire SL pair
//
// Serialises 8..32 data bits (LSB first), then an odd-parity bit, then a stop
// bit, onto the zeroes/ones line pair. Every bit is PULSE_LEN cycles of one
// line low followed by GAP_LEN cycles of both lines high. The stop bit pulls
// both lines low at once.
//
// Optional feature macro: SL_TX_PARITY_INJECT_EN
//   When defined, adds input inject_par_err. It is sampled with tx_start, and
//   when set it inverts the transmitted parity bit.
//
// Ports:
//   clk                 system clock
//   rst_n               asynchronous active-low reset
//   tx_data[31:0]       word to send; bits at index BQ and above are ignored
//   tx_start            send request, sampled only while idle
//   inject_par_err      (macro only) invert parity of the accepted frame
//   wr_config_w         new configuration value
//   wr_enable           configuration write strobe (idle only, BQ legality checked)
//   serial_line_zeroes  SL zeroes line, idle high
//   serial_line_ones    SL ones line, idle high
//   busy                frame in progress
//   tx_done             one-cycle pulse at frame end
//   r_config_w          current configuration (PCE[0], BQ[6:1], MODE/IRQM stored)

module sl_transmitter #(
   parameter int CONFIG_WIDTH = 16,
   parameter int PULSE_LEN    = 16,
   parameter int GAP_LEN      = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [31:0]             tx_data,
   input  logic                    tx_start,
`ifdef SL_TX_PARITY_INJECT_EN
   input  logic                    inject_par_err,
`endif
   input  logic [CONFIG_WIDTH-1:0] wr_config_w,
   input  logic                    wr_enable,
   output logic                    serial_line_zeroes,
   output logic                    serial_line_ones,
   output logic                    busy,
   output logic                    tx_done,
   output logic [CONFIG_WIDTH-1:0] r_config_w
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_BIT_LOW,
      S_BIT_HIGH,
      S_STOP_LOW,
      S_STOP_HIGH
   } state_t;

   localparam logic [5:0]              PULSE_LAST   = 6'(PULSE_LEN - 1);
   localparam logic [5:0]              GAP_LAST     = 6'(GAP_LEN - 1);
   localparam logic [CONFIG_WIDTH-1:0] CONFIG_RESET = CONFIG_WIDTH'(16'h0010);

   state_t      r_state;
   logic [5:0]  r_phase;
   logic [5:0]  r_bit_cnt;
   logic [5:0]  r_frame_bq;
   logic [32:0] r_shift;

   logic [5:0]  w_bq;
   logic [32:0] w_mask;
   logic [32:0] w_data_m;
   logic        w_par;
   logic [32:0] w_shift_init;
   logic [5:0]  w_cfg_bq;
   logic        w_cfg_ok;
   logic        w_inject;

`ifdef SL_TX_PARITY_INJECT_EN
   assign w_inject = inject_par_err;
`else
   assign w_inject = 1'b0;
`endif

   // The frame always uses the BQ held before any same-cycle config write.
   assign w_bq     = r_config_w[6:1];
   assign w_mask   = (33'd1 << w_bq) - 33'd1;
   assign w_data_m = {1'b0, tx_data} & w_mask;
   // Odd parity: data ones plus p is odd.
   assign w_par    = ~(^w_data_m) ^ w_inject;
   // Parity sits just above the data so it shifts out right after the last data bit.
   assign w_shift_init = w_data_m | (33'(w_par) << w_bq);

   assign w_cfg_bq = wr_config_w[6:1];
   assign w_cfg_ok = !w_cfg_bq[0] && (w_cfg_bq >= 6'd8) && (w_cfg_bq <= 6'd32);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state            <= S_IDLE;
         r_phase            <= '0;
         r_bit_cnt          <= '0;
         r_frame_bq         <= '0;
         r_shift            <= '0;
         serial_line_zeroes <= 1'b1;
         serial_line_ones   <= 1'b1;
         busy               <= 1'b0;
         tx_done            <= 1'b0;
         r_config_w         <= CONFIG_RESET;
      end else begin
         tx_done <= 1'b0;

         if (wr_enable && (r_state == S_IDLE) && w_cfg_ok)
            r_config_w <= wr_config_w;

         case (r_state)
            S_IDLE: begin
               serial_line_zeroes <= 1'b1;
               serial_line_ones   <= 1'b1;
               busy               <= 1'b0;
               if (tx_start) begin
                  r_shift            <= w_shift_init;
                  r_frame_bq         <= w_bq;
                  r_bit_cnt          <= '0;
                  r_phase            <= '0;
                  busy               <= 1'b1;
                  serial_line_zeroes <= w_shift_init[0];
                  serial_line_ones   <= ~w_shift_init[0];
                  r_state            <= S_BIT_LOW;
               end
            end

            S_BIT_LOW: begin
               if (r_phase == PULSE_LAST) begin
                  r_phase            <= '0;
                  serial_line_zeroes <= 1'b1;
                  serial_line_ones   <= 1'b1;
                  r_state            <= S_BIT_HIGH;
               end else begin
                  r_phase <= r_phase + 6'd1;
               end
            end

            S_BIT_HIGH: begin
               if (r_phase == GAP_LAST) begin
                  r_phase   <= '0;
                  r_shift   <= r_shift >> 1;
                  r_bit_cnt <= r_bit_cnt + 6'd1;
                  // r_bit_cnt == frame_bq means the parity bit just finished.
                  if (r_bit_cnt == r_frame_bq) begin
                     serial_line_zeroes <= 1'b0;
                     serial_line_ones   <= 1'b0;
                     r_state            <= S_STOP_LOW;
                  end else begin
                     // r_shift[1] is the bit that becomes shift[0] on this edge.
                     serial_line_zeroes <= r_shift[1];
                     serial_line_ones   <= ~r_shift[1];
                     r_state            <= S_BIT_LOW;
                  end
               end else begin
                  r_phase <= r_phase + 6'd1;
               end
            end

            S_STOP_LOW: begin
               if (r_phase == PULSE_LAST) begin
                  r_phase            <= '0;
                  serial_line_zeroes <= 1'b1;
                  serial_line_ones   <= 1'b1;
                  r_state            <= S_STOP_HIGH;
               end else begin
                  r_phase <= r_phase + 6'd1;
               end
            end

            S_STOP_HIGH: begin
               if (r_phase == GAP_LAST) begin
                  r_phase <= '0;
                  busy    <= 1'b0;
                  tx_done <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_phase <= r_phase + 6'd1;
               end
            end

            default: begin
               serial_line_zeroes <= 1'b1;
               serial_line_ones   <= 1'b1;
               busy               <= 1'b0;
               r_state            <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sl_transmitter.sv
// tb/tb_sl_transmitter.sv - directed self-checking bench for sl_transmitter
module tb_sl_transmitter;

   logic        clk;
   logic        rst_n;
   logic [31:0] tx_data;
   logic        tx_start;
   logic [15:0] wr_config_w;
   logic        wr_enable;
   logic        serial_line_zeroes;
   logic        serial_line_ones;
   logic        busy;
   logic        tx_done;
   logic [15:0] r_config_w;
`ifdef SL_TX_PARITY_INJECT_EN
   logic        inject_par_err;
`endif

   int checks   = 0;
   int failures = 0;

   sl_transmitter #(
      .CONFIG_WIDTH(16),
      .PULSE_LEN   (16),
      .GAP_LEN     (16)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .tx_data           (tx_data),
      .tx_start          (tx_start),
`ifdef SL_TX_PARITY_INJECT_EN
      .inject_par_err    (inject_par_err),
`endif
      .wr_config_w       (wr_config_w),
      .wr_enable         (wr_enable),
      .serial_line_zeroes(serial_line_zeroes),
      .serial_line_ones  (serial_line_ones),
      .busy              (busy),
      .tx_done           (tx_done),
      .r_config_w        (r_config_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // mode 0: single tx_start pulse
   // mode 1: tx_start held through frame plus a config write mid-frame
   // mode 2: tx_start left high (back-to-back)
   // mode 3: config write to BQ=8 in the acceptance cycle
   task automatic run_frame(input logic [31:0] data, input int bq, input logic exp_par,
                            input int mode, input string name);
      int   bad;
      int   first_bad;
      int   total;
      logic v;
      logic ez;
      logic eo;
      bad       = 0;
      first_bad = -1;
      total     = 0;
      tx_data   = data;
      tx_start  = 1'b1;
      if (mode == 3) begin
         wr_enable   = 1'b1;
         wr_config_w = 16'h0010;
      end
      @(negedge clk);
      wr_enable = 1'b0;
      tx_data   = ~data;
      if (mode == 0 || mode == 3) tx_start = 1'b0;
      for (int b = 0; b <= bq + 1; b++) begin
         for (int c = 0; c < 32; c++) begin
            if (c >= 16) begin
               ez = 1'b1; eo = 1'b1;
            end else if (b == bq + 1) begin
               ez = 1'b0; eo = 1'b0;
            end else begin
               v  = (b < bq) ? data[b] : exp_par;
               ez = v;
               eo = ~v;
            end
            if ({busy, tx_done, serial_line_zeroes, serial_line_ones} !== {1'b1, 1'b0, ez, eo}) begin
               bad++;
               if (first_bad < 0) first_bad = total;
            end
            if (mode == 1 && total == 100) begin
               wr_enable   = 1'b1;
               wr_config_w = 16'h0040;
            end
            if (mode == 1 && total == 101) wr_enable = 1'b0;
            if (mode == 1 && b == bq + 1 && c == 31) tx_start = 1'b0;
            total++;
            @(negedge clk);
         end
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL %s waveform: %0d bad cycles, first at cycle %0d, required 0 bad", name, bad, first_bad);
      end
      checks++;
      if ({busy, tx_done} !== 2'b01) begin
         failures++;
         $display("FAIL %s end: busy/tx_done=%b required 01 after %0d cycles", name, {busy, tx_done}, total);
      end
   endtask

   task automatic write_cfg(input logic [15:0] val);
      wr_config_w = val;
      wr_enable   = 1'b1;
      @(negedge clk);
      wr_enable   = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if ({serial_line_zeroes, serial_line_ones, busy, tx_done} !== 4'b1100) begin
         failures++;
         $display("FAIL reset_outputs: got %b required 1100", {serial_line_zeroes, serial_line_ones, busy, tx_done});
      end
      checks++;
      if (r_config_w !== 16'h0010) begin
         failures++;
         $display("FAIL reset_config: got %h required 0010", r_config_w);
      end
   endtask

   task automatic test_frame_a5();
      run_frame(32'h0000_00A5, 8, 1'b1, 0, "frame_a5");
      @(negedge clk);
      checks++;
      if ({busy, tx_done, serial_line_zeroes, serial_line_ones} !== 4'b0011) begin
         failures++;
         $display("FAIL a5_idle_after: got %b required 0011", {busy, tx_done, serial_line_zeroes, serial_line_ones});
      end
   endtask

   task automatic test_mask_high_bits();
      run_frame(32'hFFFF_FF5A, 8, 1'b1, 0, "mask_5a");
   endtask

   task automatic test_config();
      write_cfg(16'h0040);
      checks++;
      if (r_config_w !== 16'h0040) begin
         failures++;
         $display("FAIL cfg_bq32: got %h required 0040", r_config_w);
      end
      write_cfg(16'h000E);
      write_cfg(16'h0044);
      write_cfg(16'h0012);
      checks++;
      if (r_config_w !== 16'h0040) begin
         failures++;
         $display("FAIL cfg_reject: got %h required 0040", r_config_w);
      end
      write_cfg(16'h01C1);
      checks++;
      if (r_config_w !== 16'h01C1) begin
         failures++;
         $display("FAIL cfg_fields: got %h required 01c1", r_config_w);
      end
      run_frame(32'hFFFF_FFFF, 32, 1'b1, 0, "frame_bq32");
   endtask

   task automatic test_busy_ignore();
      int bad_idle;
      write_cfg(16'h0010);
      run_frame(32'h0000_00A5, 8, 1'b1, 1, "busy_ignore");
      checks++;
      if (r_config_w !== 16'h0010) begin
         failures++;
         $display("FAIL busy_cfg_write: got %h required 0010", r_config_w);
      end
      bad_idle = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if ({busy, serial_line_zeroes, serial_line_ones} !== 3'b011) bad_idle++;
      end
      checks++;
      if (bad_idle !== 0) begin
         failures++;
         $display("FAIL start_not_queued: %0d non-idle cycles, required 0", bad_idle);
      end
   endtask

   task automatic test_back_to_back();
      run_frame(32'h0000_00A5, 8, 1'b1, 2, "b2b_first");
      run_frame(32'h0000_0003, 8, 1'b1, 2, "b2b_second");
      tx_start = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL b2b_stop: busy=%b required 0", busy);
      end
   endtask

   task automatic test_same_cycle_cfg();
      write_cfg(16'h0040);
      run_frame(32'h0000_1234, 32, 1'b0, 3, "same_cycle_old_bq");
      checks++;
      if (r_config_w !== 16'h0010) begin
         failures++;
         $display("FAIL same_cycle_cfg: got %h required 0010", r_config_w);
      end
      run_frame(32'h0000_00A5, 8, 1'b1, 0, "same_cycle_new_bq");
   endtask

   task automatic test_bq16();
      write_cfg(16'h0020);
      run_frame(32'h0000_1234, 16, 1'b0, 0, "frame_bq16");
   endtask

   task automatic test_reset_mid();
      tx_data  = 32'h0000_00A5;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({serial_line_zeroes, serial_line_ones, busy} !== 3'b110) begin
         failures++;
         $display("FAIL reset_mid_lines: got %b required 110", {serial_line_zeroes, serial_line_ones, busy});
      end
      checks++;
      if (r_config_w !== 16'h0010) begin
         failures++;
         $display("FAIL reset_mid_config: got %h required 0010", r_config_w);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_frame(32'h0000_00A5, 8, 1'b1, 0, "after_reset");
   endtask

   initial begin
      rst_n       = 1'b0;
      tx_data     = '0;
      tx_start    = 1'b0;
      wr_config_w = '0;
      wr_enable   = 1'b0;
`ifdef SL_TX_PARITY_INJECT_EN
      inject_par_err = 1'b0;
`endif
      repeat (3) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_frame_a5();
      test_mask_high_bits();
      test_config();
      test_busy_ignore();
      test_back_to_back();
      test_same_cycle_cfg();
      test_bq16();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
